// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
//   Shared types and helpers for the multiplier arbiter.
//   - tag_t   : pipeline tag {valid, idx} that travels alongside the multiplier
//   - MAX_REQ : upper bound on requesters; the tag index is sized for it
//   - rr_pick : one-hot round-robin pick over a MAX_REQ wide valid vector
package mult_arb_pkg;

    localparam int MAX_REQ = 8;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } tag_t;

    // Searches upward from ptr and wraps modulo MAX_REQ. Callers zero-pad the
    // valid vector above their requester count, so the natural 3-bit wrap here
    // behaves exactly like a wrap modulo the real requester count.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid_vec,
                                                   input logic [2:0]         ptr);
        logic [MAX_REQ-1:0] grant;
        logic [2:0]         pos;
        logic               found;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            pos = ptr + 3'(k);
            if (!found && valid_vec[pos]) begin
                grant[pos] = 1'b1;
                found      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/mult_arbiter_mult_pipe.sv
// mult_pipe
//   Unsigned WIDTH x WIDTH multiplier with LATENCY register stages, returning
//   the full 2*WIDTH product. Kept as its own module so that a vendor
//   multiplier macro can be dropped in here without touching the arbiter; the
//   inferred form below maps onto a dedicated multiplier block with its
//   pipeline registers absorbed.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset, clears all stages
//     a, b - operands, captured every cycle
//     p    - product, valid LATENCY edges after a/b are presented
module mult_pipe #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] stage_q [LATENCY];
    logic [2*WIDTH-1:0] stage_d [LATENCY];

    always_comb begin
        stage_d[0] = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        for (int k = 1; k < LATENCY; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign p = stage_q[LATENCY-1];

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter
//   Shares one pipelined unsigned multiplier between NUM_REQ requesters.
//   One request is granted per cycle; its requester index rides a tag shift
//   register aligned with the multiplier, and the product is returned on a
//   shared bus with a one-hot rsp_valid one cycle after the last stage.
//   Build option: define MULT_ARB_FIXED_PRIO_EN for fixed priority
//   (requester 0 highest, no pointer register); default is round-robin.
//   Ports:
//     clk, reset  - clock / asynchronous active-high reset
//     req_valid   - per-requester request strobe
//     req_a/req_b - packed operands, requester i at [i*WIDTH +: WIDTH]
//     req_ready   - one-hot combinational grant (0 while reset is high)
//     rsp_valid   - one-hot, marks which requester owns rsp_result
//     rsp_result  - full 2*WIDTH product, held while rsp_valid is 0
//     busy        - any operation in flight
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int NUM_REQ      = 2,
    parameter int MULT_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     busy
);

    logic [MAX_REQ-1:0] valid_ext;
    logic [MAX_REQ-1:0] grant_full;
    logic [2:0]         grant_idx;
    logic               grant_any;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [2*WIDTH-1:0] product;

    tag_t               tag_q [MULT_LATENCY];
    tag_t               tag_d [MULT_LATENCY];
    tag_t               tag_last;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [2*WIDTH-1:0] rsp_result_q, rsp_result_d;

    // Masking with reset keeps req_ready low and stops issue during reset.
    always_comb begin
        valid_ext              = '0;
        valid_ext[NUM_REQ-1:0] = reset ? '0 : req_valid;
    end

`ifdef MULT_ARB_FIXED_PRIO_EN
    assign grant_full = rr_pick(valid_ext, 3'd0);
`else
    logic [2:0] ptr_q, ptr_d;

    assign grant_full = rr_pick(valid_ext, ptr_q);

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= 3'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign req_ready = grant_full[NUM_REQ-1:0];
    assign grant_any = |grant_full;

    // Encode the one-hot grant and steer the winner's operands.
    always_comb begin
        grant_idx = 3'd0;
        sel_a     = '0;
        sel_b     = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (grant_full[k]) begin
                grant_idx = 3'(k);
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_full[k]) begin
                sel_a = req_a[k*WIDTH +: WIDTH];
                sel_b = req_b[k*WIDTH +: WIDTH];
            end
        end
    end

    mult_pipe #(
        .WIDTH   (WIDTH),
        .LATENCY (MULT_LATENCY)
    ) u_mult_pipe (
        .clk (clk),
        .rst (reset),
        .a   (sel_a),
        .b   (sel_b),
        .p   (product)
    );

    always_comb begin
        tag_d[0].valid = grant_any;
        tag_d[0].idx   = grant_idx;
        for (int k = 1; k < MULT_LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    assign tag_last = tag_q[MULT_LATENCY-1];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_dec
            assign rsp_valid_d[gi] = tag_last.valid && (tag_last.idx == 3'(gi));
        end
    endgenerate

    // The product bus only updates when a tagged result lands.
    assign rsp_result_d = tag_last.valid ? product : rsp_result_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MULT_LATENCY; k++) begin
                tag_q[k] <= '0;
            end
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
        end else begin
            for (int k = 0; k < MULT_LATENCY; k++) begin
                tag_q[k] <= tag_d[k];
            end
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < MULT_LATENCY; k++) begin
            busy = busy | tag_q[k].valid;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mult_arbiter #(
        .WIDTH        (8),
        .NUM_REQ      (2),
        .MULT_LATENCY (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
        $display("check %-14s observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Each slot starts 1 time unit after a rising edge.
    task automatic slot;
        @(posedge clk);
        #1;
    endtask

    // Alternating-load expectations: pointer is 1 when this step begins.
`ifdef MULT_ARB_FIXED_PRIO_EN
    logic [1:0]  exp_grant [4] = '{2'b01, 2'b01, 2'b01, 2'b01};
    logic [15:0] exp_prod  [4] = '{16'd4, 16'd4, 16'd4, 16'd4};
`else
    logic [1:0]  exp_grant [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [15:0] exp_prod  [4] = '{16'd63, 16'd4, 16'd63, 16'd4};
`endif

    initial begin
        reset     = 1'b1;
        req_valid = 2'b01;
        req_a     = {8'd0, 8'd3};
        req_b     = {8'd0, 8'd5};

        // Reset state, with a request pending to confirm req_ready is masked.
        slot;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_v", 32'(rsp_valid), 32'h0);
        check("rst_result", 32'(rsp_result), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Single request 3*5, latency 2.
        slot;
        reset = 1'b0;
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        slot;
        req_valid = 2'b00;
        #1;
        check("t1_busy_a", 32'(busy), 32'h1);
        check("t1_rspv_a", 32'(rsp_valid), 32'h0);
        slot;
        check("t1_busy_b", 32'(busy), 32'h1);
        check("t1_rspv_b", 32'(rsp_valid), 32'h0);
        slot;
        check("t1_rspv", 32'(rsp_valid), 32'h1);
        check("t1_result", 32'(rsp_result), 32'd15);
        check("t1_busy_c", 32'(busy), 32'h0);
        slot;
        check("t1_rspv_off", 32'(rsp_valid), 32'h0);
        check("t1_hold", 32'(rsp_result), 32'd15);

        // Both requesters valid for 4 cycles: req0 2*2, req1 7*9.
        req_a = {8'd7, 8'd2};
        req_b = {8'd9, 8'd2};
        for (int c = 0; c < 8; c++) begin
            slot;
            req_valid = (c < 4) ? 2'b11 : 2'b00;
            #1;
            if (c < 4) begin
                check($sformatf("t2_ready%0d", c), 32'(req_ready), 32'(exp_grant[c]));
            end
            if (c >= 3 && c <= 6) begin
                check($sformatf("t2_rspv%0d", c - 3), 32'(rsp_valid), 32'(exp_grant[c-3]));
                check($sformatf("t2_prod%0d", c - 3), 32'(rsp_result), 32'(exp_prod[c-3]));
            end else begin
                check($sformatf("t2_idle%0d", c), 32'(rsp_valid), 32'h0);
            end
        end

        // Extremes: req1 0*200, then req0 255*255.
        slot;
        req_valid = 2'b10;
        req_a     = {8'd0, 8'd255};
        req_b     = {8'd200, 8'd255};
        #1;
        check("t3_ready1", 32'(req_ready), 32'h2);
        slot;
        req_valid = 2'b01;
        #1;
        check("t3_ready0", 32'(req_ready), 32'h1);
        slot;
        req_valid = 2'b00;
        slot;
        check("t3_rspv1", 32'(rsp_valid), 32'h2);
        check("t3_zero", 32'(rsp_result), 32'h0);
        slot;
        check("t3_rspv0", 32'(rsp_valid), 32'h1);
        check("t3_max", 32'(rsp_result), 32'hFE01);

        // Two issues to req0 (the second is a back-to-back re-request that wins
        // only because req1 is idle), then reset before either result is due.
        slot;
        req_valid = 2'b01;
        req_a     = {8'd0, 8'd1};
        req_b     = {8'd0, 8'd1};
        #1;
        check("t4_ready_a", 32'(req_ready), 32'h1);
        slot;
        #1;
        check("t4_ready_b", 32'(req_ready), 32'h1);
        slot;
        req_valid = 2'b00;
        reset     = 1'b1;
        #1;
        check("t4_rst_busy", 32'(busy), 32'h0);
        check("t4_rst_rspv", 32'(rsp_valid), 32'h0);
        slot;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check($sformatf("t4_norsp%0d", c), 32'(rsp_valid), 32'h0);
            check($sformatf("t4_nobusy%0d", c), 32'(busy), 32'h0);
            slot;
        end
        // Pointer must be back at 0: req0 wins against req1.
        req_valid = 2'b11;
        req_a     = {8'd9, 8'd6};
        req_b     = {8'd9, 8'd7};
        #1;
        check("t4_post_grant", 32'(req_ready), 32'h1);
        slot;
        req_valid = 2'b00;
        slot;
        slot;
        check("t4_post_rspv", 32'(rsp_valid), 32'h1);
        check("t4_post_prod", 32'(rsp_result), 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
